frame_color_classifier: RTL
===========================

Name: frame_color_classifier

Overview:
- Downstream consumer of the frame buffer read port, in parallel with the VGA driver on the 25 MHz domain.
- Watches RGB332 pixels read from M9K as the VGA scan sweeps the 176x144 image window.
- Counts red-dominant and blue-dominant pixels per frame and publishes a per-frame treasure-colour decision at the start of vertical sync.
- RESULT feeds the Arduino-facing GPIO bits.

Parameters:
- SCREEN_WIDTH, 176, active image width in pixels; pixels with X >= this are ignored.
- SCREEN_HEIGHT, 144, active image height in lines; pixels with Y >= this are ignored.
- THRESHOLD, 2000, minimum per-frame colour count for a colour to be declared.
- CNT_W, 15, counter width; must hold SCREEN_WIDTH*SCREEN_HEIGHT (25344).

Ports:
- CLK  in  1  25 MHz VGA pixel clock.
- RESET_N  in  1  asynchronous, active-low reset.
- PIXEL_IN  in  8  RGB332 memory output: R=[7:5], G=[4:2], B=[1:0]; one cycle read latency relative to VGA_PIXEL_X/Y.
- VGA_PIXEL_X  in  10  current VGA column.
- VGA_PIXEL_Y  in  10  current VGA row.
- VGA_VSYNC_NEG  in  1  active-low vertical sync from the VGA driver.
- RESULT  out  8  0=none, 1=red, 2=blue; other codes never driven.
- RESULT_VALID  out  1  one-cycle pulse when RESULT is (re)written.
- RED_COUNT  out  CNT_W  red count of the last completed frame (debug).
- BLUE_COUNT  out  CNT_W  blue count of the last completed frame (debug).

Behaviour:
- Reset (async, RESET_N=0): state=WAIT_SYNC, all counters 0, RESULT=0, RESULT_VALID=0, RED_COUNT=0, BLUE_COUNT=0, vs_d=1.
- Latency alignment: VGA_PIXEL_X/Y are registered once (x_d, y_d). PIXEL_IN in cycle n pairs with x_d/y_d. in_win = x_d<SCREEN_WIDTH && y_d<SCREEN_HEIGHT.
- Classification (combinational on PIXEL_IN):
  - red = R>=4 && G<=3 && B<=1.
  - blue = B>=2 && R<=3 && G<=3.
  - The two are mutually exclusive by construction.
- Frame edge: vs_d <= VGA_VSYNC_NEG every cycle; fe = vs_d & ~VGA_VSYNC_NEG (falling edge).
- FSM:
  - WAIT_SYNC: nothing counted; on fe -> ACCUM with counters cleared. Prevents publishing a partial first frame after reset.
  - ACCUM: each cycle with in_win, increment red_cnt if red, blue_cnt if blue. Counters saturate at 2^CNT_W-1 and never wrap. On fe -> DECIDE; the pixel in the fe cycle is not counted.
  - DECIDE (exactly one cycle):
    - Evaluate red_cnt and blue_cnt.
    - RESULT <= 1 if red_cnt>=THRESHOLD && red_cnt>blue_cnt; 2 if blue_cnt>=THRESHOLD && blue_cnt>red_cnt; else 0. A tie gives 0.
    - RED_COUNT/BLUE_COUNT <= counts; RESULT_VALID <= 1; counters cleared; -> ACCUM.
- Latency: fe seen at clock edge n. RESULT, RESULT_VALID and the debug counts update at edge n+1. RESULT_VALID is high for exactly one cycle, n+1..n+2. RESULT holds until the next DECIDE.
- RESULT_VALID fires every frame even if RESULT is unchanged.
- fe while in DECIDE is impossible for a legal VGA timing; if it occurs it is ignored.
- Reset asserted mid-frame: everything returns to reset values immediately. After release, the block waits for a full frame (WAIT_SYNC) before the first RESULT_VALID.
- All widths unsigned; comparisons are CNT_W bits wide.

Optional Feature:
- Macro: FRAME_VOTE_EN.
- Defined:
  - DECIDE computes a candidate code and keeps the previous candidate in a register.
  - RESULT updates only when the candidate equals the previous frame's candidate (two consecutive agreeing frames).
  - RESULT_VALID pulses only when RESULT actually updates.
  - The candidate register resets to 0.
- Not defined: RESULT updates every frame as above; no candidate register exists.

Test Plan:
- Reset then two frames of all pixels 8'hE0 (pure red) -> no RESULT_VALID during the first partial frame; after the second fe, RESULT=1, RED_COUNT=25344, BLUE_COUNT=0, RESULT_VALID one cycle wide, one cycle after fe.
- Frame with 3000 pixels 8'h03, rest 8'h00 -> RESULT=2, BLUE_COUNT=3000, RED_COUNT=0.
- Frame with 1999 red pixels only -> RESULT=0 (below THRESHOLD). Frame with 2500 red + 2500 blue -> RESULT=0 (tie).
- Red pixels driven only at X>=176 or Y>=144, plus one red pixel at (175,143) -> RED_COUNT=1. Also check the 1-cycle latency: PIXEL_IN red only in the cycle after (0,0) is presented -> RED_COUNT=1.
- RESET_N pulsed low mid-frame after 10000 red pixels -> RESULT=0 immediately; the next fe produces no RESULT_VALID; the following fe publishes a fresh count.
- FRAME_VOTE_EN defined: frames red, blue, blue -> RESULT stays 0 after frames 1 and 2, becomes 2 after frame 3 with a single RESULT_VALID pulse.

Source files
------------

// File: rtl/frame_color_classifier.sv
// rtl/frame_color_classifier.sv - per-frame red/blue pixel census with a colour decision at vsync.
// Build option FRAME_VOTE_EN: RESULT only changes after two consecutive frames agree.
module frame_color_classifier #(
  parameter int SCREEN_WIDTH  = 176,
  parameter int SCREEN_HEIGHT = 144,
  parameter int THRESHOLD     = 2000,
  parameter int CNT_W         = 15
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [7:0]       PIXEL_IN,
  input  logic [9:0]       VGA_PIXEL_X,
  input  logic [9:0]       VGA_PIXEL_Y,
  input  logic             VGA_VSYNC_NEG,
  output logic [7:0]       RESULT,
  output logic             RESULT_VALID,
  output logic [CNT_W-1:0] RED_COUNT,
  output logic [CNT_W-1:0] BLUE_COUNT
);

  localparam logic [9:0]       WIN_W   = 10'(SCREEN_WIDTH);
  localparam logic [9:0]       WIN_H   = 10'(SCREEN_HEIGHT);
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    ACCUM,
    DECIDE
  } state_t;

  state_t           state;
  logic [9:0]       x_d;
  logic [9:0]       y_d;
  logic             vs_d;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic             fe;
  logic             in_win;
  logic             is_red;
  logic             is_blue;
  logic [7:0]       cand;
`ifdef FRAME_VOTE_EN
  logic [7:0]       prev_cand;
`endif

  // Memory data lags the scan position by one cycle, so the window test uses the delayed position.
  assign in_win  = (x_d < WIN_W) && (y_d < WIN_H);
  assign fe      = vs_d & ~VGA_VSYNC_NEG;
  assign is_red  = (PIXEL_IN[7:5] >= 3'd4) && (PIXEL_IN[4:2] <= 3'd3) && (PIXEL_IN[1:0] <= 2'd1);
  assign is_blue = (PIXEL_IN[1:0] >= 2'd2) && (PIXEL_IN[7:5] <= 3'd3) && (PIXEL_IN[4:2] <= 3'd3);

  always_comb begin
    cand = 8'd0;
    if (red_cnt >= THR && red_cnt > blue_cnt) begin
      cand = 8'd1;
    end else if (blue_cnt >= THR && blue_cnt > red_cnt) begin
      cand = 8'd2;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= WAIT_SYNC;
      x_d          <= '0;
      y_d          <= '0;
      vs_d         <= 1'b1;
      red_cnt      <= '0;
      blue_cnt     <= '0;
      RESULT       <= 8'd0;
      RESULT_VALID <= 1'b0;
      RED_COUNT    <= '0;
      BLUE_COUNT   <= '0;
`ifdef FRAME_VOTE_EN
      prev_cand    <= 8'd0;
`endif
    end else begin
      vs_d         <= VGA_VSYNC_NEG;
      x_d          <= VGA_PIXEL_X;
      y_d          <= VGA_PIXEL_Y;
      RESULT_VALID <= 1'b0;
      case (state)
        // The first frame after reset is partial, so only start counting at a frame boundary.
        WAIT_SYNC: begin
          if (fe) begin
            state    <= ACCUM;
            red_cnt  <= '0;
            blue_cnt <= '0;
          end
        end
        ACCUM: begin
          if (fe) begin
            state <= DECIDE;
          end else if (in_win) begin
            if (is_red && red_cnt != CNT_MAX) begin
              red_cnt <= red_cnt + 1'b1;
            end
            if (is_blue && blue_cnt != CNT_MAX) begin
              blue_cnt <= blue_cnt + 1'b1;
            end
          end
        end
        DECIDE: begin
          RED_COUNT  <= red_cnt;
          BLUE_COUNT <= blue_cnt;
          red_cnt    <= '0;
          blue_cnt   <= '0;
          state      <= ACCUM;
`ifdef FRAME_VOTE_EN
          prev_cand  <= cand;
          if (cand == prev_cand) begin
            RESULT       <= cand;
            RESULT_VALID <= 1'b1;
          end
`else
          RESULT       <= cand;
          RESULT_VALID <= 1'b1;
`endif
        end
        default: begin
          state <= WAIT_SYNC;
        end
      endcase
    end
  end

endmodule
